mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-client arbiter that shares the single block-wide main-memory port between two cache controllers (e.g. I-cache and D-cache), each using the same enable/rw/addr/ready request protocol the cache controller drives toward memory. It latches one request at a time, forwards it to memory with registered outputs, waits for the memory ready strobe and returns the block data plus a one-cycle ready pulse to the granted client. Fairness is round-robin.

## Interface
- WORD_SIZE, 32, address width
- BLOCK_DATA_WIDTH, 512, block data width
- TIMEOUT_CYCLES, 255, watchdog limit in cycles, used only with ARB_TIMEOUT_EN
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- reqN_enable (N=0,1)  in  1  client request, held until its ready pulse
- reqN_rw  in  1  0 = read block, 1 = write block
- reqN_addr  in  WORD_SIZE  block address
- reqN_dataout  in  BLOCK_DATA_WIDTH  write block from client
- reqN_datain  out  BLOCK_DATA_WIDTH  read block to client (registered)
- reqN_ready  out  1  one-cycle completion pulse
- reqN_error  out  1  timeout flag, valid with reqN_ready
- mem_enable  out  1  memory request, held until mem_ready sampled
- mem_rw  out  1  forwarded rw
- mem_addr  out  WORD_SIZE  forwarded address
- mem_dataout  out  BLOCK_DATA_WIDTH  forwarded write block
- mem_datain  in  BLOCK_DATA_WIDTH  read block from memory
- mem_ready  in  1  memory completion, sampled only in ISSUE
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: sample req0_enable/req1_enable. None: stay. One: grant it. Both: grant the client not in last_grant. Latch rw/addr/dataout of winner into mem_* registers, set mem_enable=1, update last_grant, go ISSUE.
- ISSUE: hold mem_* stable. On mem_ready=1: mem_enable=0; for read, reqN_datain <= mem_datain; for write, reqN_datain unchanged; reqN_ready=1 for granted client; go RESP.
- RESP: ready pulse cycle; clear reqN_ready/reqN_error; go IDLE.
- Client rule: deassert reqN_enable on the edge at which it samples reqN_ready=1; an enable still high when IDLE samples is a new request.
- Non-granted client's enable is ignored until IDLE; it is never dropped.
- mem_ready outside ISSUE ignored. reqN_datain retains value between transactions.
- Reset (any state, async): all outputs 0, reqN_datain 0, state IDLE, last_grant=1 (client 0 wins first tie), timeout counter 0. In-flight transaction abandoned, no ready pulse.

## Timing
- Request sampled at edge E0 → mem_enable/mem_addr valid after E0.
- mem_ready sampled high at edge Ek (k≥1) → reqN_ready and reqN_datain valid after Ek, for exactly one cycle.
- IDLE after Ek+1; next grant sampled at Ek+2. Minimum request-to-ready: 1 cycle after sampling (mem_ready high at E1); minimum spacing between grants: 3 cycles.
- Arbitration and all outputs are registered; no combinational path from req*/mem_ready to outputs.

## Configuration
- ARB_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ISSUE, increments each ISSUE cycle without mem_ready; when it reaches TIMEOUT_CYCLES, mem_enable=0, reqN_ready=1 and reqN_error=1 for one cycle, reqN_datain unchanged, go RESP. mem_ready and timeout on same edge: mem_ready wins, error=0.
- Not defined: no counter; ISSUE waits indefinitely; reqN_error tied 0.

## Test plan
- req0 read addr 0x0000_0ABC alone, mem_ready after 3 cycles with block word i = 0xDEADBEEF+i → mem_addr=0x0000_0ABC, mem_rw=0, req0_datain equals block, req0_ready one cycle, busy drops after RESP.
- req0 and req1 asserted same cycle after reset → req0 granted first, req1 second; repeat simultaneous pair → req1 first (alternates).
- req1 write addr 0x0000_0DEF, dataout word0=0xCAFEBABE → mem_rw=1, mem_dataout matches, req1_datain unchanged, req1_ready pulse.
- req1 arrives while req0 in ISSUE → req1 held, granted at next IDLE, mem_* unchanged during req0 transaction.
- rst_n low mid-ISSUE → mem_enable and all outputs 0 asynchronously, no ready pulse; post-reset tie goes to req0.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted → req0_ready=1, req0_error=1 8 cycles after ISSUE entry; without macro, busy stays high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one block-wide memory port between two cache clients.
// Optional handshake watchdog is built when the macro ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0_enable,
    input  logic                        req0_rw,
    input  logic [WORD_SIZE-1:0]        req0_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] req0_dataout,
    output logic [BLOCK_DATA_WIDTH-1:0] req0_datain,
    output logic                        req0_ready,
    output logic                        req0_error,
    input  logic                        req1_enable,
    input  logic                        req1_rw,
    input  logic [WORD_SIZE-1:0]        req1_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] req1_dataout,
    output logic [BLOCK_DATA_WIDTH-1:0] req1_datain,
    output logic                        req1_ready,
    output logic                        req1_error,
    output logic                        mem_enable,
    output logic                        mem_rw,
    output logic [WORD_SIZE-1:0]        mem_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_dataout,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_datain,
    input  logic                        mem_ready,
    output logic                        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                        state_r;
    logic                          grant_r;
    logic                          last_grant_r;
    logic                          any_req_s;
    logic                          pick_s;
    logic                          win_rw_s;
    logic [WORD_SIZE-1:0]          win_addr_s;
    logic [BLOCK_DATA_WIDTH-1:0]   win_data_s;
    logic                          timeout_s;

    // Round-robin pick: on a tie the client that did not win last time goes first.
    always_comb begin
        any_req_s = req0_enable | req1_enable;
        if (req0_enable && req1_enable) begin
            pick_s = ~last_grant_r;
        end else if (req1_enable) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Request fields of the selected client.
    always_comb begin
        if (pick_s) begin
            win_rw_s   = req1_rw;
            win_addr_s = req1_addr;
            win_data_s = req1_dataout;
        end else begin
            win_rw_s   = req0_rw;
            win_addr_s = req0_addr;
            win_data_s = req0_dataout;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_r;

    // The cycle that would bring the count to the limit is the timeout cycle.
    always_comb begin
        if (state_r == ST_ISSUE && !mem_ready) begin
            timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Watchdog counter: cleared on grant, counts ISSUE cycles without mem_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_IDLE && any_req_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_ISSUE && !mem_ready && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end
    end
`else
    // Without the watchdog the limit has no effect and ISSUE waits indefinitely.
    if (TIMEOUT_CYCLES >= 0) begin : g_no_watchdog
        assign timeout_s = 1'b0;
    end
`endif

    // Arbitration FSM with all client and memory outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            busy         <= 1'b0;
            mem_enable   <= 1'b0;
            mem_rw       <= 1'b0;
            mem_addr     <= {WORD_SIZE{1'b0}};
            mem_dataout  <= {BLOCK_DATA_WIDTH{1'b0}};
            req0_datain  <= {BLOCK_DATA_WIDTH{1'b0}};
            req1_datain  <= {BLOCK_DATA_WIDTH{1'b0}};
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            req0_error   <= 1'b0;
            req1_error   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r      <= pick_s;
                        last_grant_r <= pick_s;
                        mem_rw       <= win_rw_s;
                        mem_addr     <= win_addr_s;
                        mem_dataout  <= win_data_s;
                        mem_enable   <= 1'b1;
                        busy         <= 1'b1;
                        state_r      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_enable <= 1'b0;
                        state_r    <= ST_RESP;
                        if (grant_r) begin
                            req1_ready <= 1'b1;
                            if (!mem_rw) begin
                                req1_datain <= mem_datain;
                            end
                        end else begin
                            req0_ready <= 1'b1;
                            if (!mem_rw) begin
                                req0_datain <= mem_datain;
                            end
                        end
                    end else if (timeout_s) begin
                        mem_enable <= 1'b0;
                        state_r    <= ST_RESP;
                        if (grant_r) begin
                            req1_ready <= 1'b1;
                            req1_error <= 1'b1;
                        end else begin
                            req0_ready <= 1'b1;
                            req0_error <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    req0_ready <= 1'b0;
                    req1_ready <= 1'b0;
                    req0_error <= 1'b0;
                    req1_error <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    mem_enable <= 1'b0;
                    req0_ready <= 1'b0;
                    req1_ready <= 1'b0;
                    req0_error <= 1'b0;
                    req1_error <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected client responses are queued at stimulus
// time and a monitor process pops and compares them on every ready pulse.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_enable, req0_rw, req1_enable, req1_rw;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [BW-1:0] req0_dataout, req1_dataout, req0_datain, req1_datain;
    logic          req0_ready, req0_error, req1_ready, req1_error;
    logic          mem_enable, mem_rw, mem_ready, busy;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_dataout, mem_datain;

    typedef struct {
        logic          client;
        logic [BW-1:0] data;
        logic          err;
    } resp_t;

    resp_t         exp_q[$];
    resp_t         mon_e;
    logic [BW-1:0] model0, model1;
    logic          prev0, prev1;
    int            checks = 0;
    int            errors = 0;

    mem_port_arbiter #(
        .WORD_SIZE(AW),
        .BLOCK_DATA_WIDTH(BW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_enable(req0_enable), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_dataout(req0_dataout), .req0_datain(req0_datain),
        .req0_ready(req0_ready), .req0_error(req0_error),
        .req1_enable(req1_enable), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_dataout(req1_dataout), .req1_datain(req1_datain),
        .req1_ready(req1_ready), .req1_error(req1_error),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_dataout(mem_dataout), .mem_datain(mem_datain),
        .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk_blk(input logic [31:0] base);
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) begin
            b[i*32 +: 32] = base + 32'(i);
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_expect(input logic c, input logic [BW-1:0] rdata);
        resp_t e;
        if (c) model1 = rdata; else model0 = rdata;
        e.client = c; e.data = rdata; e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic keep_expect(input logic c, input logic err);
        resp_t e;
        e.client = c; e.data = c ? model1 : model0; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drive_req(input logic c, input logic rw, input logic [AW-1:0] a,
                             input logic [BW-1:0] wd);
        if (c) begin
            req1_rw = rw; req1_addr = a; req1_dataout = wd; req1_enable = 1'b1;
        end else begin
            req0_rw = rw; req0_addr = a; req0_dataout = wd; req0_enable = 1'b1;
        end
    endtask

    task automatic wait_mem_enable(output logic ok);
        int n = 0;
        while (mem_enable !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (mem_enable === 1'b1);
        chk("mem_enable_wait", {511'd0, ok}, {511'd0, 1'b1});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {511'd0, busy}, {BW{1'b0}});
    endtask

    // Memory model: checks the forwarded request, answers after lat cycles, then the
    // client whose ready pulse appears drops its enable.
    task automatic serve(input logic rw, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                         input int lat, input logic [BW-1:0] rdata);
        logic ok;
        wait_mem_enable(ok);
        if (ok) begin
            chk("mem_rw", {511'd0, mem_rw}, {511'd0, rw});
            chk("mem_addr", {480'd0, mem_addr}, {480'd0, a});
            if (rw) chk("mem_dataout", mem_dataout, wd);
            chk("busy_active", {511'd0, busy}, {511'd0, 1'b1});
            for (int i = 1; i < lat; i++) begin
                @(negedge clk);
                chk("mem_addr_hold", {480'd0, mem_addr}, {480'd0, a});
                chk("mem_enable_hold", {511'd0, mem_enable}, {511'd0, 1'b1});
            end
            mem_datain = rdata;
            mem_ready  = 1'b1;
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_datain = {16{32'h5A5A_A5A5}};
            checks++;
            if (req0_ready === 1'b1) begin
                req0_enable = 1'b0;
            end else if (req1_ready === 1'b1) begin
                req1_enable = 1'b0;
            end else begin
                errors++;
                $display("FAIL ready_missing got 0 expected 1 for addr %0h", a);
            end
        end
    endtask

    // Scoreboard monitor: each ready pulse pops one expected response.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                checks++;
                if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                    errors++;
                    $display("FAIL ready_both got 11 expected one-hot");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready got r0=%0b r1=%0b expected none", req0_ready, req1_ready);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (req1_ready !== mon_e.client
                        || (req1_ready ? req1_datain : req0_datain) !== mon_e.data
                        || (req1_ready ? req1_error : req0_error) !== mon_e.err) begin
                        errors++;
                        $display("FAIL resp got client=%0d err=%0b data=%0h expected client=%0d err=%0b data=%0h",
                                 req1_ready, req1_ready ? req1_error : req0_error,
                                 req1_ready ? req1_datain : req0_datain,
                                 mon_e.client, mon_e.err, mon_e.data);
                    end
                end
                checks++;
                if ((req0_ready === 1'b1 && prev0 === 1'b1) || (req1_ready === 1'b1 && prev1 === 1'b1)) begin
                    errors++;
                    $display("FAIL ready_width got 2+ cycles expected 1 cycle");
                end
            end
            prev0 = req0_ready;
            prev1 = req1_ready;
        end
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0;
        req0_enable = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_dataout = '0;
        req1_enable = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_dataout = '0;
        mem_ready = 1'b0; mem_datain = '0;
        model0 = '0; model1 = '0; prev0 = 1'b0; prev1 = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_busy", {511'd0, busy}, {BW{1'b0}});
        chk("rst_mem_enable", {511'd0, mem_enable}, {BW{1'b0}});
        chk("rst_mem_addr", {480'd0, mem_addr}, {BW{1'b0}});
        chk("rst_mem_dataout", mem_dataout, {BW{1'b0}});
        chk("rst_req0_datain", req0_datain, {BW{1'b0}});
        chk("rst_req1_datain", req1_datain, {BW{1'b0}});
        chk("rst_ready_error", {508'd0, req0_ready, req1_ready, req0_error, req1_error}, {BW{1'b0}});
        rst_n = 1'b1;
        @(negedge clk);

        // First tie after reset: client 0 wins, client 1 follows.
        read_expect(1'b0, mk_blk(32'h1000_0000));
        read_expect(1'b1, mk_blk(32'h2000_0000));
        drive_req(1'b0, 1'b0, 32'h0000_0100, '0);
        drive_req(1'b1, 1'b0, 32'h0000_0200, '0);
        serve(1'b0, 32'h0000_0100, '0, 2, mk_blk(32'h1000_0000));
        serve(1'b0, 32'h0000_0200, '0, 1, mk_blk(32'h2000_0000));
        wait_idle();

        // Lone read of 0xABC, memory answers on the third ISSUE edge.
        read_expect(1'b0, mk_blk(32'hDEAD_BEEF));
        @(negedge clk);
        drive_req(1'b0, 1'b0, 32'h0000_0ABC, '0);
        @(negedge clk);
        chk("grant_latency_enable", {511'd0, mem_enable}, {511'd0, 1'b1});
        serve(1'b0, 32'h0000_0ABC, '0, 3, mk_blk(32'hDEAD_BEEF));
        @(negedge clk);
        chk("busy_after_resp", {511'd0, busy}, {BW{1'b0}});

        // Second tie: client 0 won last, so client 1 goes first.
        read_expect(1'b1, mk_blk(32'h3000_0000));
        read_expect(1'b0, mk_blk(32'h4000_0000));
        drive_req(1'b0, 1'b0, 32'h0000_0110, '0);
        drive_req(1'b1, 1'b0, 32'h0000_0210, '0);
        serve(1'b0, 32'h0000_0210, '0, 1, mk_blk(32'h3000_0000));
        serve(1'b0, 32'h0000_0110, '0, 2, mk_blk(32'h4000_0000));
        wait_idle();

        // Client 1 write: block forwarded, datain keeps its previous read value.
        keep_expect(1'b1, 1'b0);
        @(negedge clk);
        drive_req(1'b1, 1'b1, 32'h0000_0DEF, mk_blk(32'hCAFE_BABE));
        serve(1'b1, 32'h0000_0DEF, mk_blk(32'hCAFE_BABE), 2, {16{32'hFFFF_0000}});
        wait_idle();

        // Client 1 arrives mid-transaction and waits for the next IDLE.
        read_expect(1'b0, mk_blk(32'h5000_0000));
        read_expect(1'b1, mk_blk(32'h6000_0000));
        @(negedge clk);
        drive_req(1'b0, 1'b0, 32'h0000_0300, '0);
        fork
            serve(1'b0, 32'h0000_0300, '0, 4, mk_blk(32'h5000_0000));
            begin
                @(negedge clk);
                @(negedge clk);
                drive_req(1'b1, 1'b0, 32'h0000_0400, '0);
            end
        join
        serve(1'b0, 32'h0000_0400, '0, 1, mk_blk(32'h6000_0000));
        wait_idle();

        // Reset during ISSUE of a lone client-0 read: everything clears, no pulse.
        @(negedge clk);
        drive_req(1'b0, 1'b0, 32'h0000_0500, '0);
        wait_mem_enable(ok);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_enable", {511'd0, mem_enable}, {BW{1'b0}});
        chk("arst_busy", {511'd0, busy}, {BW{1'b0}});
        chk("arst_mem_addr", {480'd0, mem_addr}, {BW{1'b0}});
        chk("arst_req0_datain", req0_datain, {BW{1'b0}});
        chk("arst_req1_datain", req1_datain, {BW{1'b0}});
        chk("arst_ready", {510'd0, req0_ready, req1_ready}, {BW{1'b0}});
        req0_enable = 1'b0;
        model0 = '0;
        model1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Client 0 won before reset, but reset restores client-0 priority on a tie.
        read_expect(1'b0, mk_blk(32'h7000_0000));
        read_expect(1'b1, mk_blk(32'h8000_0000));
        drive_req(1'b0, 1'b0, 32'h0000_0700, '0);
        drive_req(1'b1, 1'b0, 32'h0000_0800, '0);
        serve(1'b0, 32'h0000_0700, '0, 1, mk_blk(32'h7000_0000));
        serve(1'b0, 32'h0000_0800, '0, 3, mk_blk(32'h8000_0000));
        wait_idle();

        // Memory never answers.
        @(negedge clk);
`ifdef ARB_TIMEOUT_EN
        keep_expect(1'b0, 1'b1);
        drive_req(1'b0, 1'b0, 32'h0000_0900, '0);
        wait_mem_enable(ok);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("timeout_early", {511'd0, req0_ready}, {BW{1'b0}});
        end
        @(negedge clk);
        chk("timeout_ready", {511'd0, req0_ready}, {511'd0, 1'b1});
        chk("timeout_mem_enable", {511'd0, mem_enable}, {BW{1'b0}});
        req0_enable = 1'b0;
        wait_idle();
`else
        drive_req(1'b0, 1'b0, 32'h0000_0900, '0);
        wait_mem_enable(ok);
        repeat (20) @(negedge clk);
        chk("hang_busy", {511'd0, busy}, {511'd0, 1'b1});
        chk("hang_mem_enable", {511'd0, mem_enable}, {511'd0, 1'b1});
        chk("hang_no_ready", {510'd0, req0_ready, req0_error}, {BW{1'b0}});
        rst_n = 1'b0;
        req0_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", BW'(exp_q.size()), {BW{1'b0}});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
